// File: rtl/audio_adc_rx_if.sv
// Sample-pair stream from the I2S ADC receiver to its consumer.
// The master side (the receiver) drives the held pair, valid and overrun, and the consumer drives ready.
interface audio_adc_rx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] left_o;
  logic [DATA_W-1:0] right_o;
  logic              valid_o;
  logic              ready_i;
  logic              overrun_o;

  modport master (
    output left_o, right_o, valid_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  left_o, right_o, valid_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronizes the codec pins and deserializes left/right words.
// Completed pairs are held behind a valid/ready handshake with a sticky overrun flag.
module audio_adc_rx #(
  parameter int DATA_W = 16
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           enable_i,
  input  logic           bclk_i,
  input  logic           adclrck_i,
  input  logic           adcdat_i,
  audio_adc_rx_if.master bus
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

  logic [1:0]        bclkSync_q, lrckSync_q, datSync_q;
  logic              bclkPrev_q, lrckPrev_q;
  logic              bclkRise, lrckEdge, lrck, dat;

  state_t            state_q, state_d;
  logic [CW-1:0]     bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] leftWord_q, leftWord_d;
  logic              leftDone_q, leftDone_d;
  logic              chan_q, chan_d;
  logic [DATA_W-1:0] word;
  logic              pairDone;

  logic [DATA_W-1:0] leftOut_q, rightOut_q;
  logic              valid_q, overrun_q;

  assign bclkRise = bclkSync_q[1] & ~bclkPrev_q;
  assign lrckEdge = lrckSync_q[1] ^ lrckPrev_q;
  assign lrck     = lrckSync_q[1];
  assign dat      = datSync_q[1];
  assign word     = {shift_q[DATA_W-2:0], dat};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bclkSync_q <= '0;
      lrckSync_q <= '0;
      datSync_q  <= '0;
      bclkPrev_q <= 1'b0;
      lrckPrev_q <= 1'b0;
    end else begin
      bclkSync_q <= {bclkSync_q[0], bclk_i};
      lrckSync_q <= {lrckSync_q[0], adclrck_i};
      datSync_q  <= {datSync_q[0], adcdat_i};
      bclkPrev_q <= bclkSync_q[1];
      lrckPrev_q <= lrckSync_q[1];
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    leftWord_d = leftWord_q;
    leftDone_d = leftDone_q;
    chan_d     = chan_q;
    pairDone   = 1'b0;
    if (!enable_i) begin
      state_d    = IDLE;
      bitCnt_d   = '0;
      shift_d    = '0;
      leftDone_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (lrckEdge && !lrck) state_d = SKIP;
        // An LRCK edge coinciding with a BCLK rise restarts the skip slot.
        SKIP: if (!lrckEdge && bclkRise) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
          shift_d  = '0;
          chan_d   = lrck;
          if (!lrck) leftDone_d = 1'b0;
        end
        SHIFT: begin
          if (lrckEdge) begin
            state_d    = SKIP;
            bitCnt_d   = '0;
            shift_d    = '0;
            leftDone_d = 1'b0;
          end else if (bclkRise) begin
            shift_d  = word;
            bitCnt_d = bitCnt_q + CW'(1);
            if (bitCnt_q == CW'(DATA_W - 1)) begin
              state_d = WAIT;
              if (!chan_q) begin
                leftWord_d = word;
                leftDone_d = 1'b1;
              end else begin
                pairDone   = leftDone_q;
                leftDone_d = 1'b0;
              end
            end
          end
        end
        WAIT: if (lrckEdge) state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      leftWord_q <= '0;
      leftDone_q <= 1'b0;
      chan_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      leftWord_q <= leftWord_d;
      leftDone_q <= leftDone_d;
      chan_q     <= chan_d;
    end
  end

  // A pair arriving while an unconsumed one is held is dropped, not merged.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      leftOut_q  <= '0;
      rightOut_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (pairDone && (!valid_q || bus.ready_i)) begin
      leftOut_q  <= leftWord_q;
      rightOut_q <= word;
      valid_q    <= 1'b1;
    end else if (pairDone) begin
      overrun_q  <= 1'b1;
    end else if (valid_q && bus.ready_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign bus.left_o    = leftOut_q;
  assign bus.right_o   = rightOut_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: drives I2S frames bit by bit and scoreboards delivered pairs.
`timescale 1ns/1ps
module tb_audio_adc_rx;
  localparam int DW   = 16;
  localparam int HALF = 4;

  logic clock_i = 1'b0;
  logic reset_i, enable_i, bclk_i, adclrck_i, adcdat_i;

  audio_adc_rx_if #(.DATA_W(DW)) bus();

  audio_adc_rx #(.DATA_W(DW)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .bclk_i    (bclk_i),
    .adclrck_i (adclrck_i),
    .adcdat_i  (adcdat_i),
    .bus       (bus)
  );

  always #10 clock_i = ~clock_i;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  int          expValidCyc = 0;
  logic [31:0] expQ[$];
  logic [31:0] monPair;
  bit          markRise = 1'b0;
  bit          latArmed = 1'b0;
  logic        validPrev = 1'b0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One BCLK period: LRCK and data change with BCLK low, then BCLK rises.
  task automatic applyStimulus(input logic lr, input logic d);
    @(posedge clock_i); #1;
    bclk_i    = 1'b0;
    adclrck_i = lr;
    adcdat_i  = d;
    repeat (HALF) @(posedge clock_i);
    #1 bclk_i = 1'b1;
    if (markRise) begin
      expValidCyc = cyc + 3;
      latArmed    = 1'b1;
      markRise    = 1'b0;
    end
    repeat (HALF - 1) @(posedge clock_i);
  endtask

  // The skip bit carries the inverse of the MSB so a missed skip corrupts the word.
  task automatic sendSlot(input logic lr, input logic [15:0] w, input int nData, input int nPad, input bit armLast);
    applyStimulus(lr, ~w[15]);
    for (int i = 0; i < nData; i++) begin
      if (armLast && i == nData - 1) markRise = 1'b1;
      applyStimulus(lr, w[15-i]);
    end
    for (int i = 0; i < nPad; i++) applyStimulus(lr, 1'b0);
  endtask

  task automatic sendFrame(input logic [15:0] l, input logic [15:0] r, input int nPad, input bit expectPair);
    if (expectPair) expQ.push_back({l, r});
    sendSlot(1'b0, l, DW, nPad, 1'b0);
    sendSlot(1'b1, r, DW, nPad, expectPair);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (bus.valid_o && !validPrev && latArmed) begin
        checkOutput("latency", cyc, expValidCyc);
        latArmed = 1'b0;
      end
      validPrev = bus.valid_o;
      if (bus.valid_o && bus.ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousValid", {31'd0, bus.valid_o}, 32'd0);
        end else begin
          monPair = expQ.pop_front();
          checkOutput("left", bus.left_o, monPair[31:16]);
          checkOutput("right", bus.right_o, monPair[15:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_i     = 1'b1;
    enable_i    = 1'b1;
    bus.ready_i = 1'b0;
    bclk_i      = 1'b0;
    adclrck_i   = 1'b0;
    adcdat_i    = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    checkOutput("rstLeft", bus.left_o, 0);
    checkOutput("rstRight", bus.right_o, 0);
    checkOutput("rstValid", bus.valid_o, 0);
    checkOutput("rstOverrun", bus.overrun_o, 0);
    @(posedge clock_i); #1 reset_i = 1'b0;
    bus.ready_i = 1'b1;

    // Start mid-right-slot: nothing may be delivered before the first full frame.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'(i % 2));

    sendFrame(16'h1234, 16'hABCD, 0, 1'b1);
    idle(8);
    checkOutput("t1QueueEmpty", expQ.size(), 0);
    checkOutput("t1Overrun", bus.overrun_o, 0);

    sendFrame(16'hFFFF, 16'hFFFF, 8, 1'b1);
    idle(8);
    checkOutput("t2QueueEmpty", expQ.size(), 0);

    // Left slot cut short after 10 bits: the following right word must be dropped.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'(i % 3 == 0));
    sendSlot(1'b1, 16'h2222, DW, 0, 1'b0);
    sendFrame(16'h2468, 16'h1357, 0, 1'b1);
    idle(8);
    checkOutput("t3QueueEmpty", expQ.size(), 0);

    bus.ready_i = 1'b0;
    sendFrame(16'h0001, 16'h0002, 0, 1'b0);
    idle(4);
    checkOutput("t4aValid", bus.valid_o, 1);
    checkOutput("t4aOverrun", bus.overrun_o, 0);
    checkOutput("t4aLeft", bus.left_o, 16'h0001);
    sendFrame(16'h8000, 16'h7FFF, 0, 1'b0);
    idle(4);
    checkOutput("t4bLeft", bus.left_o, 16'h0001);
    checkOutput("t4bRight", bus.right_o, 16'h0002);
    checkOutput("t4bValid", bus.valid_o, 1);
    checkOutput("t4bOverrun", bus.overrun_o, 1);
    expQ.push_back({16'h0001, 16'h0002});
    bus.ready_i = 1'b1;
    idle(4);
    checkOutput("t4Drained", bus.valid_o, 0);
    checkOutput("t4Sticky", bus.overrun_o, 1);

    // Enable dropped mid-left-word: that frame is lost, capture resumes at the next left start.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    #1 enable_i = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    #1 enable_i = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
    sendSlot(1'b1, 16'h3333, DW, 0, 1'b0);
    sendFrame(16'h7777, 16'h8888, 0, 1'b1);
    idle(8);
    checkOutput("t5QueueEmpty", expQ.size(), 0);
    checkOutput("t5Overrun", bus.overrun_o, 1);

    // Reset pulse during bit 7 of a left word.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'(i % 2));
    @(posedge clock_i); #1 reset_i = 1'b1;
    @(negedge clock_i);
    checkOutput("midRstLeft", bus.left_o, 0);
    checkOutput("midRstRight", bus.right_o, 0);
    checkOutput("midRstValid", bus.valid_o, 0);
    checkOutput("midRstOverrun", bus.overrun_o, 0);
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
    validPrev = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'(i % 2));
    sendSlot(1'b1, 16'hC3C3, DW, 0, 1'b0);
    sendFrame(16'h5A5A, 16'hA5A5, 0, 1'b1);

    idle(20);
    checkOutput("finalQueueEmpty", expQ.size(), 0);
    checkOutput("latencyPending", {31'd0, latArmed}, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
